// File: rtl/phy_rx_pkg.sv
// Shared types for the multilane serial receiver: lane state encoding and
// a helper that sizes saturating counters.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        SYNC   = 2'd2
    } lane_state_e;

    // Bits needed to hold values 0..max_val inclusive (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/phy_rx_lane.sv
// One receive lane: shifts in a serial bit per enabled cycle, hunts for the
// comma, tracks symbol phase and deserialises aligned symbols while in SYNC.
module phy_rx_lane
    import phy_rx_pkg::*;
#(
    parameter int               SYM_W    = 8,
    parameter logic [SYM_W-1:0] COMMA    = SYM_W'(8'hBC),
    parameter int               LOCK_CNT = 2,
    parameter int               LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             din,
    output logic [SYM_W-1:0] sym_data,
    output logic             sym_valid,
    output logic             sym_comma,
    output logic             lane_sync,
    output logic             lane_sync_next
);

    localparam int BW = $clog2(SYM_W);
    localparam int LW = cnt_width(LOCK_CNT);
    localparam int SW = cnt_width(LOSS_CNT);

    localparam logic [BW-1:0] LAST_BIT = BW'(SYM_W - 1);
    localparam logic [LW-1:0] LOCK_TGT = LW'(LOCK_CNT);
    localparam logic [SW-1:0] LOSS_TGT = SW'(LOSS_CNT);

    lane_state_e      state_q, state_d;
    logic [SYM_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [SW-1:0]    loss_cnt_q, loss_cnt_d;
    logic [SYM_W-1:0] sym_data_q, sym_data_d;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_comma_q, sym_comma_d;
    logic             lane_sync_q, lane_sync_d;

    logic [SYM_W-1:0] nxt;
    logic             is_comma;
    logic             boundary;

    // The bit arriving this cycle takes part in every comparison, so all
    // decisions are made on the shifted value rather than the stored one.
    always_comb begin
        nxt      = {shreg_q[SYM_W-2:0], din};
        is_comma = (nxt == COMMA);
        boundary = (bit_cnt_q == LAST_BIT);

        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        sym_data_d  = sym_data_q;
        sym_valid_d = 1'b0;
        sym_comma_d = 1'b0;

        if (enable) begin
            shreg_d   = nxt;
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;

            unique case (state_q)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt_d  = '0;
                        lock_cnt_d = LW'(1);
                        state_d    = (LOCK_CNT == 1) ? SYNC : ALIGN;
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (is_comma) begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                            if (lock_cnt_q + 1'b1 == LOCK_TGT) begin
                                state_d = SYNC;
                            end
                        end else begin
                            state_d    = SEARCH;
                            lock_cnt_d = '0;
                        end
                    end
                end
                SYNC: begin
                    // Only commas seen off the symbol boundary count towards loss.
                    if (boundary) begin
                        sym_data_d  = nxt;
                        sym_valid_d = 1'b1;
                        sym_comma_d = is_comma;
                        if (is_comma) begin
                            loss_cnt_d = '0;
                        end
                    end else if (is_comma) begin
                        if (loss_cnt_q + 1'b1 == LOSS_TGT) begin
                            state_d    = SEARCH;
                            loss_cnt_d = '0;
                        end else begin
                            loss_cnt_d = loss_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        lane_sync_d = (state_d == SYNC);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SEARCH;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            lock_cnt_q  <= '0;
            loss_cnt_q  <= '0;
            sym_data_q  <= '0;
            sym_valid_q <= 1'b0;
            sym_comma_q <= 1'b0;
            lane_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            sym_data_q  <= sym_data_d;
            sym_valid_q <= sym_valid_d;
            sym_comma_q <= sym_comma_d;
            lane_sync_q <= lane_sync_d;
        end
    end

    assign sym_data       = sym_data_q;
    assign sym_valid      = sym_valid_q;
    assign sym_comma      = sym_comma_q;
    assign lane_sync      = lane_sync_q;
    assign lane_sync_next = lane_sync_d;

endmodule

// File: rtl/phy_rx_multilane.sv
// Multilane serial receiver: independent per-lane comma alignment with an
// aggregate all-lanes-synchronised flag.
module phy_rx_multilane
    import phy_rx_pkg::*;
#(
    parameter int               LANES    = 2,
    parameter int               SYM_W    = 8,
    parameter logic [SYM_W-1:0] COMMA    = SYM_W'(8'hBC),
    parameter int               LOCK_CNT = 2,
    parameter int               LOSS_CNT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [LANES-1:0]       din,
    output logic [LANES*SYM_W-1:0] sym_data,
    output logic [LANES-1:0]       sym_valid,
    output logic [LANES-1:0]       sym_comma,
    output logic [LANES-1:0]       lane_sync,
    output logic                   all_sync
);

    logic [SYM_W-1:0] lane_data [LANES];
    logic [LANES-1:0] lane_sync_next;
    logic             all_sync_q, all_sync_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        phy_rx_lane #(
            .SYM_W    (SYM_W),
            .COMMA    (COMMA),
            .LOCK_CNT (LOCK_CNT),
            .LOSS_CNT (LOSS_CNT)
        ) u_lane (
            .clk            (clk),
            .reset          (reset),
            .enable         (enable),
            .din            (din[g]),
            .sym_data       (lane_data[g]),
            .sym_valid      (sym_valid[g]),
            .sym_comma      (sym_comma[g]),
            .lane_sync      (lane_sync[g]),
            .lane_sync_next (lane_sync_next[g])
        );

        assign sym_data[g*SYM_W +: SYM_W] = lane_data[g];
    end

    // Built from the lanes' next-state sync so it rises with the last lane_sync.
    always_comb begin
        all_sync_d = &lane_sync_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            all_sync_q <= 1'b0;
        end else begin
            all_sync_q <= all_sync_d;
        end
    end

    assign all_sync = all_sync_q;

endmodule

// File: tb/tb_phy_rx_multilane.sv
// Self-checking bench for phy_rx_multilane: directed scenarios then random
// traffic, every cycle compared against a phase-based reference model.
module tb_phy_rx_multilane;

    localparam int         LANES    = 2;
    localparam int         SYM_W    = 8;
    localparam int         LOCK_CNT = 2;
    localparam int         LOSS_CNT = 4;
    localparam logic [7:0] COMMA    = 8'hBC;

    logic                   clk    = 1'b0;
    logic                   reset  = 1'b0;
    logic                   enable = 1'b0;
    logic [LANES-1:0]       din    = '0;
    logic [LANES*SYM_W-1:0] sym_data;
    logic [LANES-1:0]       sym_valid;
    logic [LANES-1:0]       sym_comma;
    logic [LANES-1:0]       lane_sync;
    logic                   all_sync;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=hunting, 1=confirming, 2=locked; symbol phase is
    // the number of bits received since the anchoring comma, modulo SYM_W.
    int         m_mode   [LANES];
    int         m_bits   [LANES];
    int         m_anchor [LANES];
    int         m_locks  [LANES];
    int         m_losses [LANES];
    logic [7:0] m_hist   [LANES];
    logic [7:0] e_data   [LANES];
    logic       e_valid  [LANES];
    logic       e_comma  [LANES];
    logic       e_sync   [LANES];
    logic       e_all;

    bit q0[$];
    bit q1[$];

    phy_rx_multilane #(
        .LANES    (LANES),
        .SYM_W    (SYM_W),
        .COMMA    (COMMA),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .din       (din),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_comma (sym_comma),
        .lane_sync (lane_sync),
        .all_sync  (all_sync)
    );

    always #5 clk = ~clk;

    task automatic modelStep(input logic rst, input logic en, input logic [LANES-1:0] bits);
        logic [7:0] w;
        logic       c;
        logic       aligned;
        for (int i = 0; i < LANES; i++) begin
            if (!rst) begin
                m_mode[i]   = 0;
                m_bits[i]   = 0;
                m_anchor[i] = 0;
                m_locks[i]  = 0;
                m_losses[i] = 0;
                m_hist[i]   = '0;
                e_data[i]   = '0;
                e_valid[i]  = 1'b0;
                e_comma[i]  = 1'b0;
            end else if (!en) begin
                e_valid[i] = 1'b0;
                e_comma[i] = 1'b0;
            end else begin
                m_hist[i]  = {m_hist[i][6:0], bits[i]};
                m_bits[i]  = m_bits[i] + 1;
                w          = m_hist[i];
                c          = (w == COMMA);
                aligned    = (((m_bits[i] - m_anchor[i]) % SYM_W) == 0);
                e_valid[i] = 1'b0;
                e_comma[i] = 1'b0;
                if (m_mode[i] == 0) begin
                    if (c) begin
                        m_anchor[i] = m_bits[i];
                        m_locks[i]  = 1;
                        m_mode[i]   = (LOCK_CNT == 1) ? 2 : 1;
                    end
                end else if (m_mode[i] == 1) begin
                    if (aligned) begin
                        if (c) begin
                            m_locks[i] = m_locks[i] + 1;
                            if (m_locks[i] == LOCK_CNT) m_mode[i] = 2;
                        end else begin
                            m_mode[i]  = 0;
                            m_locks[i] = 0;
                        end
                    end
                end else begin
                    if (aligned) begin
                        e_data[i]  = w;
                        e_valid[i] = 1'b1;
                        e_comma[i] = c;
                        if (c) m_losses[i] = 0;
                    end else if (c) begin
                        m_losses[i] = m_losses[i] + 1;
                        if (m_losses[i] == LOSS_CNT) begin
                            m_mode[i]   = 0;
                            m_losses[i] = 0;
                        end
                    end
                end
            end
            e_sync[i] = rst && (m_mode[i] == 2);
        end
        e_all = 1'b1;
        for (int i = 0; i < LANES; i++) e_all = e_all & e_sync[i];
    endtask

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < LANES; i++) begin
            checkValue($sformatf("sym_valid[%0d]", i), 16'(sym_valid[i]), 16'(e_valid[i]));
            checkValue($sformatf("sym_data[%0d]", i), 16'(sym_data[i*SYM_W +: SYM_W]), 16'(e_data[i]));
            checkValue($sformatf("lane_sync[%0d]", i), 16'(lane_sync[i]), 16'(e_sync[i]));
            if (e_valid[i]) begin
                checkValue($sformatf("sym_comma[%0d]", i), 16'(sym_comma[i]), 16'(e_comma[i]));
            end
        end
        checkValue("all_sync", 16'(all_sync), 16'(e_all));
    endtask

    // One clock: present inputs, let the edge happen, then compare #1 later.
    task automatic applyStimulus(input logic en, input logic rst);
        reset  = rst;
        enable = en;
        din    = '0;
        if (en && rst) begin
            if (q0.size() > 0) din[0] = q0.pop_front();
            if (q1.size() > 0) din[1] = q1.pop_front();
        end
        @(posedge clk);
        modelStep(rst, en, din);
        #1;
        checkOutput();
    endtask

    task automatic pushSym(input int lane, input logic [7:0] s);
        for (int b = SYM_W - 1; b >= 0; b--) begin
            if (lane == 0) q0.push_back(s[b]);
            else           q1.push_back(s[b]);
        end
    endtask

    task automatic pushBits(input int lane, input int n, input logic [7:0] v);
        for (int b = n - 1; b >= 0; b--) begin
            if (lane == 0) q0.push_back(v[b]);
            else           q1.push_back(v[b]);
        end
    endtask

    task automatic drain();
        while (q0.size() > 0 || q1.size() > 0) applyStimulus(1'b1, 1'b1);
    endtask

    task automatic pushRandom(input int lane);
        int r;
        r = $urandom_range(0, 99);
        if (r < 35)      pushSym(lane, COMMA);
        else if (r < 42) pushBits(lane, 1, 8'($urandom_range(0, 1)));
        else             pushSym(lane, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        modelStep(1'b0, 1'b0, '0);

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkValue("reset sym_valid", 16'(sym_valid), 16'h0);
        checkValue("reset lane_sync", 16'(lane_sync), 16'h0);
        checkValue("reset all_sync", 16'(all_sync), 16'h0);
        checkValue("reset sym_data", sym_data, 16'h0);

        $display("[TB] lock both lanes, lane1 skewed by 3 bits");
        pushBits(0, 4, 8'h00);
        pushSym(0, COMMA); pushSym(0, COMMA); pushSym(0, COMMA); pushSym(0, 8'h5A);
        pushBits(0, 3, 8'h00);
        pushBits(1, 7, 8'h00);
        pushSym(1, COMMA); pushSym(1, COMMA); pushSym(1, COMMA); pushSym(1, 8'h5A);
        drain();
        checkValue("t2 lane_sync", 16'(lane_sync), 16'h3);
        checkValue("t2 all_sync", 16'(all_sync), 16'h1);
        checkValue("t2 lane1 data", 16'(sym_data[15:8]), 16'h5A);
        checkValue("t2 lane1 comma", 16'(sym_comma[1]), 16'h0);

        $display("[TB] align abort");
        applyStimulus(1'b1, 1'b0);
        pushSym(0, COMMA); pushSym(0, 8'h00);
        pushBits(1, 8, 8'h00); pushBits(1, 8, 8'h00);
        drain();
        checkValue("t3 lane_sync", 16'(lane_sync), 16'h0);
        checkValue("t3 sym_valid", 16'(sym_valid), 16'h0);

        $display("[TB] bit slip and relock");
        pushSym(0, COMMA); pushSym(0, COMMA);
        pushBits(0, 1, 8'h00);
        for (int k = 0; k < 6; k++) pushSym(0, COMMA);
        pushSym(0, 8'h5A);
        drain();
        checkValue("t4 lane_sync0", 16'(lane_sync[0]), 16'h1);
        checkValue("t4 lane0 data", 16'(sym_data[7:0]), 16'h5A);

        $display("[TB] enable stall mid-symbol");
        pushBits(0, 4, 8'h0C);
        drain();
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1);
        pushBits(0, 4, 8'h03);
        drain();
        checkValue("t5 sym_valid", 16'(sym_valid), 16'h1);
        checkValue("t5 lane0 data", 16'(sym_data[7:0]), 16'hC3);

        $display("[TB] reset mid-symbol");
        pushBits(0, 3, 8'h05);
        drain();
        applyStimulus(1'b1, 1'b0);
        checkValue("t6 sym_valid", 16'(sym_valid), 16'h0);
        checkValue("t6 lane_sync", 16'(lane_sync), 16'h0);
        checkValue("t6 sym_data", sym_data, 16'h0);
        pushSym(0, COMMA); pushSym(0, COMMA); pushSym(0, 8'h5A);
        drain();
        checkValue("t6 relock sync", 16'(lane_sync[0]), 16'h1);
        checkValue("t6 relock data", 16'(sym_data[7:0]), 16'h5A);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            if (q0.size() == 0) pushRandom(0);
            if (q1.size() == 0) pushRandom(1);
            applyStimulus(($urandom_range(0, 99) >= 8) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 999) >= 3) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
